// File: rtl/adder_rr_arbiter_if.sv
// Request, adder and response channels of the shared-adder arbiter.
// The slave modport is the arbiter's view; the master modport is the clients' and adder's view.
interface adder_rr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DW      = 10
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]    i_req_valid;
  logic [NUM_REQ-1:0]    o_req_ready;
  logic [NUM_REQ*DW-1:0] i_req_a;
  logic [NUM_REQ*DW-1:0] i_req_b;
  logic [NUM_REQ-1:0]    i_req_cin;
  logic                  o_add_enable;
  logic [DW-1:0]         o_add_a;
  logic [DW-1:0]         o_add_b;
  logic                  o_add_cin;
  logic                  i_add_valid;
  logic [DW:0]           i_add_result;
  logic                  o_rsp_valid;
  logic [IDW-1:0]        o_rsp_id;
  logic [DW:0]           o_rsp_result;
  logic                  i_rsp_ready;
  logic                  o_busy;

  modport slave (
    input  i_req_valid, i_req_a, i_req_b, i_req_cin,
    input  i_add_valid, i_add_result, i_rsp_ready,
    output o_req_ready, o_add_enable, o_add_a, o_add_b, o_add_cin,
    output o_rsp_valid, o_rsp_id, o_rsp_result, o_busy
  );

  modport master (
    output i_req_valid, i_req_a, i_req_b, i_req_cin,
    output i_add_valid, i_add_result, i_rsp_ready,
    input  o_req_ready, o_add_enable, o_add_a, o_add_b, o_add_cin,
    input  o_rsp_valid, o_rsp_id, o_rsp_result, o_busy
  );
endinterface

// File: rtl/adder_rr_arbiter.sv
// Round-robin arbiter sharing one registered adder among NUM_REQ requesters,
// one operation in flight, result returned with the owner's ID on a valid/ready channel.
module adder_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DW      = 10
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  adder_rr_arbiter_if.slave bus
);
  localparam int IDW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t             state_q, state_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [IDW-1:0]     id_q, id_d;
  logic [DW-1:0]      a_q, a_d;
  logic [DW-1:0]      b_q, b_d;
  logic               cin_q, cin_d;
  logic [DW:0]        res_q, res_d;
  logic               add_en_q, add_en_d;
  logic               rsp_vld_q, rsp_vld_d;
  logic               busy_q, busy_d;
  logic [IDW-1:0]     win;
  logic               found;
  logic [NUM_REQ-1:0] req_ready;

  // First valid requester at or after the pointer, wrapping past NUM_REQ-1.
  always_comb begin
    int             cand;
    logic [IDW-1:0] cidx;
    found = 1'b0;
    win   = '0;
    cand  = 0;
    cidx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = (int'(ptr_q) + i) % NUM_REQ;
      cidx = IDW'(cand);
      if (!found && bus.i_req_valid[cidx]) begin
        found = 1'b1;
        win   = cidx;
      end
    end
  end

  // Ready is masked by reset so it reads zero while the block is held in reset.
  always_comb begin
    req_ready = '0;
    if (i_rstn && (state_q == IDLE) && found) begin
      req_ready[win] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          a_d     = bus.i_req_a[int'(win)*DW +: DW];
          b_d     = bus.i_req_b[int'(win)*DW +: DW];
          cin_d   = bus.i_req_cin[win];
          id_d    = win;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (bus.i_add_valid) begin
          res_d   = bus.i_add_result;
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.i_rsp_ready) begin
          ptr_d   = (int'(id_q) == NUM_REQ - 1) ? '0 : id_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    add_en_d  = (state_d == ISSUE);
    rsp_vld_d = (state_d == RESP);
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      id_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      cin_q     <= 1'b0;
      res_q     <= '0;
      add_en_q  <= 1'b0;
      rsp_vld_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      id_q      <= id_d;
      a_q       <= a_d;
      b_q       <= b_d;
      cin_q     <= cin_d;
      res_q     <= res_d;
      add_en_q  <= add_en_d;
      rsp_vld_q <= rsp_vld_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.o_req_ready  = req_ready;
  assign bus.o_add_enable = add_en_q;
  assign bus.o_add_a      = a_q;
  assign bus.o_add_b      = b_q;
  assign bus.o_add_cin    = cin_q;
  assign bus.o_rsp_valid  = rsp_vld_q;
  assign bus.o_rsp_id     = id_q;
  assign bus.o_rsp_result = res_q;
  assign bus.o_busy       = busy_q;
endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Bench for adder_rr_arbiter: vector table, directed multi-cycle sequences and a
// randomized phase against a transaction-level round-robin model.
module tb_adder_rr_arbiter;
  localparam int N  = 4;
  localparam int DW = 10;

  typedef struct {
    int            k;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          cin;
    logic [N-1:0]  exp_ready;
    logic [1:0]    exp_id;
    logic [DW:0]   exp_res;
  } vec_t;

  typedef struct {
    int            id;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          cin;
    logic [DW:0]   res;
  } op_t;

  logic i_clk;
  logic i_rstn;

  adder_rr_arbiter_if #(.NUM_REQ(N), .DW(DW)) bus ();

  adder_rr_arbiter #(.NUM_REQ(N), .DW(DW)) dut (
    .i_clk (i_clk),
    .i_rstn(i_rstn),
    .bus   (bus.slave)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Registered adder with one cycle of latency.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      bus.i_add_valid  <= 1'b0;
      bus.i_add_result <= '0;
    end else begin
      bus.i_add_valid  <= bus.o_add_enable;
      bus.i_add_result <= {1'b0, bus.o_add_a} + {1'b0, bus.o_add_b} + {{DW{1'b0}}, bus.o_add_cin};
    end
  end

  int   n_cmp = 0;
  int   n_err = 0;
  vec_t vecs[7];
  int   g_ids[$];
  int   g_cyc[$];
  int   exp3[5] = '{0, 1, 2, 3, 0};
  int   exp4[4] = '{1, 3, 1, 3};
  int   en_cnt, rsp_cnt, mptr, w, age, n_ops;
  logic [N-1:0] gprev, exp_rdy;
  op_t  q[$];
  op_t  op;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge i_clk);
    #1;
  endtask

  task automatic clear_reqs();
    bus.i_req_valid = '0;
    bus.i_req_a     = '0;
    bus.i_req_b     = '0;
    bus.i_req_cin   = '0;
  endtask

  task automatic set_req(input int k, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic cin);
    bus.i_req_valid[k[1:0]]   = 1'b1;
    bus.i_req_a[k*DW +: DW]   = a;
    bus.i_req_b[k*DW +: DW]   = b;
    bus.i_req_cin[k[1:0]]     = cin;
  endtask

  task automatic do_reset();
    i_rstn = 1'b0;
    clear_reqs();
    bus.i_rsp_ready = 1'b0;
    tick();
    tick();
    i_rstn = 1'b1;
    #1;
  endtask

  function automatic int onehot_idx(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) if (v[k]) return k;
    return -1;
  endfunction

  function automatic int rr_pick(input int p, input logic [N-1:0] v);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [DW-1:0] rnd_opnd();
    case ($urandom_range(0, 3))
      0:       return '1;
      1:       return '0;
      default: return DW'($urandom_range(0, 1023));
    endcase
  endfunction

  // One isolated operation from IDLE, checking grant, issue, latency and response.
  task automatic run_vec(input string tag, input vec_t v);
    set_req(v.k, v.a, v.b, v.cin);
    #1;
    chk({tag, "_ready"}, 32'(bus.o_req_ready), 32'(v.exp_ready));
    tick();
    clear_reqs();
    #1;
    chk({tag, "_enable"}, 32'(bus.o_add_enable), 32'd1);
    chk({tag, "_add_a"}, 32'(bus.o_add_a), 32'(v.a));
    chk({tag, "_add_b"}, 32'(bus.o_add_b), 32'(v.b));
    chk({tag, "_add_cin"}, 32'(bus.o_add_cin), 32'(v.cin));
    tick();
    chk({tag, "_enable_off"}, 32'(bus.o_add_enable), 32'd0);
    chk({tag, "_early_rsp"}, 32'(bus.o_rsp_valid), 32'd0);
    tick();
    chk({tag, "_rsp_valid"}, 32'(bus.o_rsp_valid), 32'd1);
    chk({tag, "_rsp_id"}, 32'(bus.o_rsp_id), 32'(v.exp_id));
    chk({tag, "_rsp_result"}, 32'(bus.o_rsp_result), 32'(v.exp_res));
    bus.i_rsp_ready = 1'b1;
    tick();
    chk({tag, "_rsp_drop"}, 32'(bus.o_rsp_valid), 32'd0);
    chk({tag, "_busy_off"}, 32'(bus.o_busy), 32'd0);
    bus.i_rsp_ready = 1'b0;
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, 10'd5,    10'd7,    1'b0, 4'b0001, 2'd0, 11'd12};
    vecs[1] = '{2, 10'd1023, 10'd1023, 1'b1, 4'b0100, 2'd2, 11'd2047};
    vecs[2] = '{1, 10'd512,  10'd511,  1'b0, 4'b0010, 2'd1, 11'd1023};
    vecs[3] = '{3, 10'd1023, 10'd1,    1'b0, 4'b1000, 2'd3, 11'd1024};
    vecs[4] = '{0, 10'd0,    10'd0,    1'b1, 4'b0001, 2'd0, 11'd1};
    vecs[5] = '{3, 10'd100,  10'd200,  1'b1, 4'b1000, 2'd3, 11'd301};
    vecs[6] = '{1, 10'd0,    10'd0,    1'b0, 4'b0010, 2'd1, 11'd0};

    // Reset state, with a request pending and the consumer ready.
    i_rstn = 1'b0;
    clear_reqs();
    bus.i_rsp_ready = 1'b1;
    set_req(0, 10'd5, 10'd7, 1'b0);
    tick();
    tick();
    chk("rst_req_ready", 32'(bus.o_req_ready), 32'd0);
    chk("rst_add_enable", 32'(bus.o_add_enable), 32'd0);
    chk("rst_rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
    chk("rst_busy", 32'(bus.o_busy), 32'd0);
    chk("rst_rsp_id", 32'(bus.o_rsp_id), 32'd0);
    chk("rst_rsp_result", 32'(bus.o_rsp_result), 32'd0);
    chk("rst_add_a", 32'(bus.o_add_a), 32'd0);
    chk("rst_add_b", 32'(bus.o_add_b), 32'd0);
    clear_reqs();
    bus.i_rsp_ready = 1'b0;
    i_rstn = 1'b1;
    #1;

    for (int i = 0; i < 7; i++) run_vec($sformatf("v%0d", i), vecs[i]);

    // All four requesting continuously: 0,1,2,3,0 at four-cycle spacing.
    do_reset();
    for (int k = 0; k < N; k++) set_req(k, rnd_opnd(), rnd_opnd(), 1'($urandom_range(0, 1)));
    bus.i_rsp_ready = 1'b1;
    #1;
    g_ids.delete();
    g_cyc.delete();
    en_cnt = 0;
    rsp_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus.o_req_ready != '0) begin
        g_ids.push_back(onehot_idx(bus.o_req_ready));
        g_cyc.push_back(c);
      end
      if (bus.o_add_enable) en_cnt++;
      if (bus.o_rsp_valid && bus.i_rsp_ready) rsp_cnt++;
      tick();
    end
    chk("t3_grant_count", 32'(g_ids.size()), 32'd5);
    for (int i = 0; i < 5 && i < g_ids.size(); i++) begin
      chk($sformatf("t3_grant%0d_id", i), 32'(g_ids[i]), 32'(exp3[i]));
      if (i > 0) chk($sformatf("t3_grant%0d_spacing", i), 32'(g_cyc[i] - g_cyc[i-1]), 32'd4);
    end
    chk("t3_enables", 32'(en_cnt), 32'd5);
    chk("t3_responses", 32'(rsp_cnt), 32'd5);

    // Requesters 1 and 3 only: pointer skips the idle ones.
    do_reset();
    set_req(1, 10'd11, 10'd22, 1'b0);
    set_req(3, 10'd33, 10'd44, 1'b1);
    bus.i_rsp_ready = 1'b1;
    #1;
    g_ids.delete();
    for (int c = 0; c < 16; c++) begin
      if (bus.o_req_ready != '0) g_ids.push_back(onehot_idx(bus.o_req_ready));
      tick();
    end
    chk("t4_grant_count", 32'(g_ids.size()), 32'd4);
    for (int i = 0; i < 4 && i < g_ids.size(); i++)
      chk($sformatf("t4_grant%0d_id", i), 32'(g_ids[i]), 32'(exp4[i]));

    // Backpressure for five cycles in RESP with another request pending.
    do_reset();
    set_req(0, 10'd300, 10'd400, 1'b1);
    #1;
    chk("t5_first_ready", 32'(bus.o_req_ready), 32'b0001);
    tick();
    clear_reqs();
    set_req(1, 10'd20, 10'd30, 1'b1);
    #1;
    chk("t5_enable", 32'(bus.o_add_enable), 32'd1);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t5_hold%0d_valid", i), 32'(bus.o_rsp_valid), 32'd1);
      chk($sformatf("t5_hold%0d_id", i), 32'(bus.o_rsp_id), 32'd0);
      chk($sformatf("t5_hold%0d_result", i), 32'(bus.o_rsp_result), 32'd701);
      chk($sformatf("t5_hold%0d_no_grant", i), 32'(bus.o_req_ready), 32'd0);
      if (i < 4) tick();
    end
    bus.i_rsp_ready = 1'b1;
    #1;
    chk("t5_accept_cycle_no_grant", 32'(bus.o_req_ready), 32'd0);
    tick();
    bus.i_rsp_ready = 1'b0;
    #1;
    chk("t5_rsp_dropped", 32'(bus.o_rsp_valid), 32'd0);
    chk("t5_grant_resumes", 32'(bus.o_req_ready), 32'b0010);
    tick();
    clear_reqs();
    #1;
    chk("t5_second_add_a", 32'(bus.o_add_a), 32'd20);
    tick();
    tick();
    chk("t5_second_id", 32'(bus.o_rsp_id), 32'd1);
    chk("t5_second_result", 32'(bus.o_rsp_result), 32'd51);
    bus.i_rsp_ready = 1'b1;
    tick();
    bus.i_rsp_ready = 1'b0;

    // Reset during WAIT: operation abandoned, pointer back to 0.
    do_reset();
    run_vec("t6pre", '{1, 10'd3, 10'd4, 1'b0, 4'b0010, 2'd1, 11'd7});
    set_req(2, 10'd9, 10'd9, 1'b0);
    #1;
    chk("t6_grant2", 32'(bus.o_req_ready), 32'b0100);
    tick();
    clear_reqs();
    tick();
    chk("t6_busy_in_wait", 32'(bus.o_busy), 32'd1);
    i_rstn = 1'b0;
    #1;
    chk("t6_rst_busy", 32'(bus.o_busy), 32'd0);
    chk("t6_rst_enable", 32'(bus.o_add_enable), 32'd0);
    chk("t6_rst_rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
    chk("t6_rst_add_a", 32'(bus.o_add_a), 32'd0);
    chk("t6_rst_rsp_result", 32'(bus.o_rsp_result), 32'd0);
    tick();
    tick();
    i_rstn = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t6_no_rsp%0d", i), 32'(bus.o_rsp_valid), 32'd0);
      chk($sformatf("t6_idle%0d", i), 32'(bus.o_busy), 32'd0);
      tick();
    end
    set_req(0, 10'd1, 10'd2, 1'b0);
    set_req(2, 10'd5, 10'd6, 1'b0);
    #1;
    chk("t6_grant_after_reset", 32'(bus.o_req_ready), 32'b0001);

    // Randomized traffic against the transaction-level model.
    do_reset();
    mptr = 0;
    q.delete();
    gprev = '0;
    age = 0;
    n_ops = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N; k++) begin
        if (gprev[k]) bus.i_req_valid[k[1:0]] = 1'b0;
        else if (!bus.i_req_valid[k[1:0]] && $urandom_range(0, 2) == 0)
          set_req(k, rnd_opnd(), rnd_opnd(), 1'($urandom_range(0, 1)));
      end
      gprev = '0;
      bus.i_rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      chk("rnd_busy", 32'(bus.o_busy), 32'(q.size() != 0));
      exp_rdy = '0;
      w = -1;
      if (q.size() == 0) begin
        w = rr_pick(mptr, bus.i_req_valid);
        if (w >= 0) exp_rdy[w] = 1'b1;
      end
      chk("rnd_req_ready", 32'(bus.o_req_ready), 32'(exp_rdy));
      if (bus.o_req_ready != '0) begin
        gprev = bus.o_req_ready;
        if (q.size() == 0 && w >= 0) begin
          op.id  = w;
          op.a   = bus.i_req_a[w*DW +: DW];
          op.b   = bus.i_req_b[w*DW +: DW];
          op.cin = bus.i_req_cin[w];
          op.res = {1'b0, op.a} + {1'b0, op.b} + {{DW{1'b0}}, op.cin};
          q.push_back(op);
          mptr = (w + 1) % N;
        end
      end
      if (bus.o_add_enable) begin
        chk("rnd_enable_inflight", 32'(q.size()), 32'd1);
        if (q.size() != 0) begin
          chk("rnd_add_a", 32'(bus.o_add_a), 32'(q[0].a));
          chk("rnd_add_b", 32'(bus.o_add_b), 32'(q[0].b));
          chk("rnd_add_cin", 32'(bus.o_add_cin), 32'(q[0].cin));
        end
      end
      if (bus.o_rsp_valid && bus.i_rsp_ready) begin
        chk("rnd_rsp_inflight", 32'(q.size()), 32'd1);
        if (q.size() != 0) begin
          chk("rnd_rsp_id", 32'(bus.o_rsp_id), 32'(q[0].id));
          chk("rnd_rsp_result", 32'(bus.o_rsp_result), 32'(q[0].res));
          void'(q.pop_front());
          n_ops++;
        end
      end
      if (q.size() != 0) age++;
      else age = 0;
      if (age > 64) begin
        chk("rnd_rsp_timeout", 32'(age), 32'd0);
        q.delete();
        age = 0;
      end
      tick();
    end
    chk("rnd_ops_completed", 32'(n_ops > 100), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/adder_rr_arbiter.md
Name: adder_rr_arbiter

Overview:
Shares one registered 10-bit adder (1-cycle latency, enable/valid interface) between NUM_REQ requesters.
- Round-robin arbitration selects one requester.
- The block latches that requester's operands and drives one enable pulse into the adder.
- It captures the adder result and returns it with the requester ID over a valid/ready response channel.
- It sits between client blocks and the adder instance; only one operation is in flight at a time.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DW, 10, operand width; adder result is DW+1 bits
IDW, 2, response ID width = clog2(NUM_REQ) (derived, not overridden)

Ports:
i_clk  input  1  clock, all logic on posedge
i_rstn  input  1  asynchronous active-low reset
i_req_valid  input  NUM_REQ  per-requester request valid
o_req_ready  output  NUM_REQ  per-requester accept (one-hot or zero)
i_req_a  input  NUM_REQ*DW  packed operand A, requester k at [k*DW +: DW]
i_req_b  input  NUM_REQ*DW  packed operand B, same packing
i_req_cin  input  NUM_REQ  per-requester carry-in
o_add_enable  output  1  enable pulse to adder
o_add_a  output  DW  operand A to adder
o_add_b  output  DW  operand B to adder
o_add_cin  output  1  carry-in to adder
i_add_valid  input  1  adder result valid
i_add_result  input  DW+1  adder result {cout,sum}
o_rsp_valid  output  1  response valid
o_rsp_id  output  IDW  index of requester owning the response
o_rsp_result  output  DW+1  captured result
i_rsp_ready  input  1  response consumer ready
o_busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (i_rstn low, asynchronous):
  - State = IDLE; round-robin pointer = 0.
  - Operand registers = 0; o_rsp_result = 0; o_rsp_id = 0.
  - o_rsp_valid, o_add_enable and o_busy are 0; o_req_ready = 0.
- Reset asserted mid-operation aborts the operation. The in-flight request is lost, and no response is issued after release.
- States: IDLE, ISSUE, WAIT, RESP. State, pointer and all output registers are registered.
- IDLE:
  - o_req_ready[g] = 1 combinationally for the winner g. The winner is the first index with i_req_valid set, searching from pointer upward with wrap-around (pointer, pointer+1, ..., NUM_REQ-1, 0, ...).
  - On that edge: latch i_req_a/b/cin of g and ID g, then go to ISSUE.
  - With no request: o_req_ready = 0 and the block stays in IDLE.
  - A requester must hold valid and operands stable until it sees ready.
- ISSUE:
  - o_add_enable = 1 for exactly this one cycle.
  - o_add_a/b/cin are driven from the operand registers; they are held at their last value in all other states.
  - Next state is WAIT.
- WAIT:
  - On i_add_valid = 1: capture i_add_result into o_rsp_result, then go to RESP.
  - No timeout.
  - i_add_valid in any state other than WAIT is ignored.
- RESP:
  - o_rsp_valid = 1; o_rsp_id and o_rsp_result are stable until accepted.
  - Accepted on a cycle with i_rsp_ready = 1. On that edge: pointer = (g+1) mod NUM_REQ, o_rsp_valid falls, next state is IDLE.
  - No new request is granted in the same cycle as response acceptance.
- Latency with the 1-cycle adder: accepted at edge T, o_add_enable high in cycle T..T+1, result captured at T+2, o_rsp_valid high from T+2. Minimum 4 cycles per operation with i_rsp_ready held high.
- Fairness: a continuously requesting requester is granted within NUM_REQ operations.
- Arithmetic: no width change. The result is passed through as DW+1 bits, and the carry is preserved in bit DW.

Test Plan:
1. Reset release, requester 0 only, a=5 b=7 cin=0 -> o_req_ready=4'b0001 for one cycle; one o_add_enable pulse with a=5 b=7; o_rsp_valid 2 cycles after enable, id=0, result=12.
2. Overflow: requester 2, a=1023 b=1023 cin=1 -> rsp id=2, result=2047 (bit 10 set).
3. All four requesters valid continuously, i_rsp_ready=1 -> grant order 0,1,2,3,0; exactly one o_add_enable per response; 4 cycles per operation.
4. Requesters 1 and 3 valid, pointer=2 after a grant to 1 -> grants 3 then 1; requesters 0 and 2 are never granted.
5. Backpressure: i_rsp_ready=0 for 5 cycles in RESP -> o_rsp_valid, id and result held constant; o_req_ready stays 0 despite pending requests; grant resumes the cycle after acceptance.
6. i_rstn pulsed low during WAIT -> all outputs 0 immediately; no response after release; next grant goes to requester 0 if valid.
